// File: rtl/ec_pkg.sv
// ec_pkg: shared constants for the EC memory arbiter.
//   EC_ADDR_W / EC_DATA_W : default memory geometry (32 x 8)
//   ec_state_e            : arbiter phase encoding, also used by the status
//                           display and benches (IDLE=00 LOAD=01 RUN=10 HALT=11)
package ec_pkg;

  localparam int unsigned EC_ADDR_W = 5;
  localparam int unsigned EC_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_HALT = 2'b11
  } ec_state_e;

endpackage

// File: rtl/ec_mem_req_reg.sv
// ec_mem_req_reg: registered memory request stage with a 2:1 source select.
// The CPU source has priority over the loader source. All outputs are flops.
//   clk, rst                    : clock, async active-high reset
//   cpu_fire, cpu_we/addr/wdata : CPU request accepted this cycle
//   ld_fire, ld_addr/ld_data    : loader write accepted this cycle
//   mem_addr/mem_we/mem_wdata   : registered memory port
//   cpu_gnt                     : CPU access presented to memory this cycle
module ec_mem_req_reg
  import ec_pkg::*;
#(
  parameter int unsigned ADDR_W = EC_ADDR_W,
  parameter int unsigned DATA_W = EC_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_fire,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              ld_fire,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_gnt
);

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              cpu_gnt_q, cpu_gnt_d;

  // Source select; address/data hold when idle, strobes fall to zero.
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    cpu_gnt_d   = 1'b0;
    if (cpu_fire) begin
      mem_addr_d  = cpu_addr;
      mem_wdata_d = cpu_wdata;
      mem_we_d    = cpu_we;
      cpu_gnt_d   = 1'b1;
    end else if (ld_fire) begin
      mem_addr_d  = ld_addr;
      mem_wdata_d = ld_data;
      mem_we_d    = 1'b1;
    end
  end

  // Async reset drops mem_we immediately so no partial write follows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      cpu_gnt_q   <= 1'b0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      cpu_gnt_q   <= cpu_gnt_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign cpu_gnt   = cpu_gnt_q;

endmodule

// File: rtl/ec_mem_arbiter.sv
// ec_mem_arbiter: shares the EC processor's single memory port between the
// CPU and an external program loader, and sequences IDLE/LOAD/RUN/HALT.
// Optional macro LD_CYCLE_STEAL_EN lets the loader write during RUN in
// cycles where the CPU is not requesting (CPU has strict priority).
//   clk, rst                       : clock, async active-high reset
//   load_start, run_start          : phase control pulses
//   ld_valid/ld_ready/ld_addr/ld_data/ld_last : loader write handshake
//   cpu_req/cpu_we/cpu_addr/cpu_wdata, cpu_gnt : CPU memory access
//   cpu_halt, cpu_hold             : halt from CU, hold CU/PC in reset
//   mem_addr/mem_we/mem_wdata      : registered memory port
//   word_cnt                       : words loaded since last load_start
//   state                          : current phase
module ec_mem_arbiter
  import ec_pkg::*;
#(
  parameter int unsigned ADDR_W = EC_ADDR_W,
  parameter int unsigned DATA_W = EC_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              run_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  input  logic              cpu_halt,
  output logic              cpu_hold,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W:0]   word_cnt,
  output logic [1:0]        state
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

  ec_state_e         state_q, state_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              ld_fire;
  logic              cpu_fire;

  // Loader acceptance depends on phase (and on CPU idleness when stealing).
  always_comb begin
    ld_ready = (state_q == ST_LOAD);
`ifdef LD_CYCLE_STEAL_EN
    if (state_q == ST_RUN) begin
      ld_ready = ~cpu_req;
    end
`endif
  end

  assign ld_fire  = ld_valid & ld_ready;
  assign cpu_fire = (state_q == ST_RUN) & cpu_req;
  assign cnt_inc  = (word_cnt_q == DEPTH_C) ? word_cnt_q : word_cnt_q + CNT_W'(1);

  // Next-state and word counter.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d    = ST_LOAD;
          word_cnt_d = '0;
        end else if (run_start) begin
          state_d = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (ld_fire) begin
          word_cnt_d = cnt_inc;
          if (ld_last || (cnt_inc == DEPTH_C)) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // ld_fire can only be true here when cycle stealing is built in.
        if (ld_fire) begin
          word_cnt_d = cnt_inc;
        end
        if (cpu_halt) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (load_start) begin
          state_d    = ST_LOAD;
          word_cnt_d = '0;
        end else if (run_start) begin
          state_d = ST_RUN;
        end
      end
    endcase
    cpu_hold_d = (state_d != ST_RUN);
  end

  // Phase, counter and hold registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= '0;
      cpu_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      cpu_hold_q <= cpu_hold_d;
    end
  end

  ec_mem_req_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_req_reg (
    .clk       (clk),
    .rst       (rst),
    .cpu_fire  (cpu_fire),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .ld_fire   (ld_fire),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .cpu_gnt   (cpu_gnt)
  );

  assign state    = state_q;
  assign word_cnt = word_cnt_q;
  assign cpu_hold = cpu_hold_q;

endmodule

// File: doc/ec_mem_arbiter.md
Name: ec_mem_arbiter

Overview:
- Owns the single 32x8 program/data memory port of the EC processor and shares it between two requesters: the control unit/datapath (CPU) and an external program loader.
- Sequences the machine through load, run and halt phases.
- Holds the control unit in reset (`cpu_hold`) while memory is being loaded.
- Sits between the CU/datapath memory signals (Meminst/MemWr path) and the memory macro.

Parameters:
- ADDR_W, 5, memory address width (DEPTH = 2**ADDR_W words)
- DATA_W, 8, memory word width

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- load_start  in  1  single-cycle pulse: begin loading
- run_start  in  1  single-cycle pulse: start or restart execution
- ld_valid  in  1  loader write request
- ld_ready  out  1  loader request accepted this cycle when `ld_valid` & `ld_ready`
- ld_addr  in  ADDR_W  loader write address
- ld_data  in  DATA_W  loader write data
- ld_last  in  1  marks the final loader word
- cpu_req  in  1  CPU memory access request
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  pulse: CPU access presented to memory this cycle
- cpu_halt  in  1  Halt from control unit
- cpu_hold  out  1  holds CU/PC in reset
- mem_addr  out  ADDR_W  registered memory address
- mem_we  out  1  registered memory write enable
- mem_wdata  out  DATA_W  registered memory write data
- word_cnt  out  ADDR_W+1  words loaded since last `load_start`
- state  out  2  IDLE=00, LOAD=01, RUN=10, HALT=11

Behaviour:
- Reset (async, active-high):
  - `state` = IDLE.
  - `cpu_hold` = 1.
  - `ld_ready`, `cpu_gnt`, `mem_we` = 0.
  - `mem_addr`, `mem_wdata`, `word_cnt` = 0.
- All memory outputs are registered: a request accepted in cycle N appears on `mem_*` in cycle N+1. `cpu_gnt` is asserted in cycle N+1 with `mem_*`. `mem_we` is high exactly one cycle per accepted write.
- IDLE:
  - `cpu_hold`=1, `ld_ready`=0.
  - `load_start` → LOAD and clear `word_cnt`.
  - else `run_start` → RUN.
  - Both asserted together: `load_start` wins.
- LOAD:
  - `cpu_hold`=1, `ld_ready`=1.
  - Each handshake registers a write of `ld_data` to `ld_addr` and increments `word_cnt`.
  - `word_cnt` saturates at DEPTH.
  - Handshake with `ld_last`=1 → RUN on the next edge; the final write still issues.
  - `word_cnt` reaching DEPTH → RUN.
  - `load_start`, `run_start`, `cpu_req` and `cpu_halt` are ignored.
- RUN:
  - `cpu_hold`=0, `ld_ready`=0 (see optional feature).
  - `cpu_req` registers `cpu_addr`/`cpu_we`/`cpu_wdata` onto `mem_*`.
  - No `cpu_req` → `mem_we`=0 and `mem_addr` holds its last value.
  - `cpu_halt`=1 → HALT. A request sampled in the same cycle is still issued.
- HALT:
  - `cpu_hold`=1, `ld_ready`=0, `cpu_req` ignored.
  - `load_start` → LOAD (reload; `word_cnt` cleared).
  - else `run_start` → RUN (restart from PC=0 via the `cpu_hold` release).
- Reset mid-LOAD or mid-RUN: returns to IDLE immediately. `mem_we` drops asynchronously, so no partial write follows.
- Unused encodings: none (2-bit, all four states legal).

Optional Feature:
- Macro: LD_CYCLE_STEAL_EN.
- Defined: in RUN, `ld_ready` = ~`cpu_req`. The CPU has strict priority. A loader write is accepted in any RUN cycle without a CPU request, registered identically and counted in `word_cnt`. `ld_last` has no state effect in RUN.
- Undefined: `ld_ready`=0 in RUN; RUN behaviour exactly as above.

Decomposition:
- Shared package `ec_pkg`:
  - state enum constants ST_IDLE/ST_LOAD/ST_RUN/ST_HALT
  - default ADDR_W/DATA_W constants
  - encoding also used by the top-level status display and benches
- One natural sub-module, `ec_mem_req_reg`: the registered address/data/we/grant output stage with a 2:1 source select. The FSM and counter stay in the parent.

Test Plan:
- Reset asserted mid-cycle with `ld_valid`=1 in LOAD → `state`=00, `cpu_hold`=1, `mem_we`=0 immediately; `word_cnt`=0.
- `load_start`, then 3 handshakes (addr 0,1,2; data 8'hA0,8'hA1,8'hA2, last on third) → `mem_we` pulses at cycles +1; `word_cnt`=3; `state`=10 and `cpu_hold`=0 after the third write.
- Full load of 32 words without `ld_last` → `word_cnt`=32 (6'b100000), automatic transition to RUN; a 33rd `ld_valid` sees `ld_ready`=0.
- RUN: `cpu_req` write addr 5'h1F data 8'h3C → next cycle `mem_addr`=1F, `mem_wdata`=3C, `mem_we`=1, `cpu_gnt`=1; read request → `mem_we`=0, `cpu_gnt`=1.
- RUN: `cpu_halt`=1 → `state`=11, `cpu_hold`=1. Then `load_start` and `run_start` together → LOAD, `word_cnt`=0.
- With LD_CYCLE_STEAL_EN in RUN: alternating `cpu_req`=1/0 and `ld_valid`=1 throughout → `ld_ready` only in CPU-idle cycles; CPU and loader writes interleave; no cycle has both granted. Without the macro: `ld_ready` stays 0.
